// File: rtl/uart_rx_oversampler.sv
// 16x-oversampling UART receiver: 2-flop synchroniser, start-glitch rejection, 3-sample majority vote, framing check.
// Define UART_RX_PARITY_EN for 8E1 framing with even-parity checking; the default build is 8N1 with parity_err tied low.
module uart_rx_oversampler #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       rx_en,
  output logic       rx_done,
  output logic [7:0] rx_out,
  output logic       frame_err,
  output logic       parity_err
);
  localparam int          DIV      = CLK_FREQ / (BAUD * OVERSAMPLE);
  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_STOP   = 3'd3;
  localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
  localparam logic [2:0] S_PARITY = 3'd5;
`endif

  logic [1:0]  sync_q, sync_d;
  logic [2:0]  state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [3:0]  phase_q, phase_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic        v7_q, v7_d, v8_q, v8_d;
  logic [7:0]  rx_out_q, rx_out_d;
  logic        rx_done_q, rx_done_d;
  logic        frame_err_q, frame_err_d;
  logic        parity_err_q, parity_err_d;
`ifdef UART_RX_PARITY_EN
  logic        parity_bad_q, parity_bad_d;
`endif
  logic        rxs, tick, decide, bit_end, vote;

  assign rxs     = sync_q[1];
  assign tick    = (div_q == DIV_LAST);
  assign decide  = tick && (phase_q == 4'd9);
  assign bit_end = tick && (phase_q == 4'd15);
  // Samples from ticks 7 and 8 are held; the tick-9 sample is the live rxs.
  assign vote    = (v7_q & v8_q) | (v7_q & rxs) | (v8_q & rxs);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    sync_d       = {sync_q[0], rx};
    state_d      = state_q;
    div_d        = div_q;
    phase_d      = phase_q;
    bit_d        = bit_q;
    shift_d      = shift_q;
    v7_d         = v7_q;
    v8_d         = v8_q;
    rx_out_d     = rx_out_q;
    rx_done_d    = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_d = parity_bad_q;
`endif

    if (state_q != S_IDLE) begin
      div_d = tick ? 16'd0 : div_q + 16'd1;
      if (tick) phase_d = phase_q + 4'd1;
      if (tick && phase_q == 4'd7) v7_d = rxs;
      if (tick && phase_q == 4'd8) v8_d = rxs;
    end

    case (state_q)
      S_IDLE: begin
        if (!rxs) begin
          state_d = S_START;
          div_d   = 16'd0;
          phase_d = 4'd0;
        end
      end
      S_START: begin
        if (decide && vote) begin
          state_d = S_IDLE;
        end else if (bit_end) begin
          state_d = S_DATA;
          bit_d   = 3'd0;
        end
      end
      S_DATA: begin
        if (decide) shift_d = {vote, shift_q[7:1]};
        if (bit_end) begin
          bit_d = bit_q + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_q == 3'd7) state_d = S_PARITY;
`else
          if (bit_q == 3'd7) state_d = S_STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      S_PARITY: begin
        if (decide) parity_bad_d = vote ^ (^shift_q);
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        // Deciding at tick 9 and going idle leaves half a stop bit to catch the next start edge.
        if (decide) begin
          if (vote) begin
`ifdef UART_RX_PARITY_EN
            if (parity_bad_q) begin
              parity_err_d = 1'b1;
            end else begin
              rx_done_d = 1'b1;
              rx_out_d  = shift_q;
            end
`else
            rx_done_d = 1'b1;
            rx_out_d  = shift_q;
`endif
            state_d = S_IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        if (rxs) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (!rx_en) begin
      state_d      = S_IDLE;
      rx_out_d     = rx_out_q;
      rx_done_d    = 1'b0;
      frame_err_d  = 1'b0;
      parity_err_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q       <= 2'b11;
      state_q      <= S_IDLE;
      div_q        <= 16'd0;
      phase_q      <= 4'd0;
      bit_q        <= 3'd0;
      shift_q      <= 8'd0;
      v7_q         <= 1'b0;
      v8_q         <= 1'b0;
      rx_out_q     <= 8'd0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= 1'b0;
`endif
    end else begin
      sync_q       <= sync_d;
      state_q      <= state_d;
      div_q        <= div_d;
      phase_q      <= phase_d;
      bit_q        <= bit_d;
      shift_q      <= shift_d;
      v7_q         <= v7_d;
      v8_q         <= v8_d;
      rx_out_q     <= rx_out_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
`ifdef UART_RX_PARITY_EN
      parity_bad_q <= parity_bad_d;
`endif
    end
  end

  assign rx_done    = rx_done_q;
  assign rx_out     = rx_out_q;
  assign frame_err  = frame_err_q;
  assign parity_err = parity_err_q;
endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Scoreboard bench for uart_rx_oversampler at DIV=10 (160 clocks per bit).
// Expected events are queued as frames are driven and retired by a monitor sampling on the falling edge.
module tb_uart_rx_oversampler;
  localparam int DIV = 10;
  localparam int BIT = 16 * DIV;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_CLKS = 16 * DIV;
`else
  localparam int PAR_CLKS = 0;
`endif
  // rx_done appears 154*DIV..154*DIV+4 after rxs first reads low, which trails the rx edge by 2-3 clocks.
  localparam int LAT_LO = 154 * DIV + PAR_CLKS + 2;
  localparam int LAT_HI = 154 * DIV + PAR_CLKS + 7;

  localparam logic [2:0] EV_DONE = 3'b100;
  localparam logic [2:0] EV_FERR = 3'b010;
  localparam logic [2:0] EV_PERR = 3'b001;

  typedef struct {
    logic [2:0] kind;
    logic [7:0] data;
    bit         chk_lat;
    int         start_cyc;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic       rx_en;
  logic       rx_done;
  logic [7:0] rx_out;
  logic       frame_err;
  logic       parity_err;

  int         n_cmp = 0;
  int         n_mis = 0;
  int         cyc   = 0;
  ev_t        sb[$];
  logic [7:0] exp_out = 8'h00;

  uart_rx_oversampler #(
    .CLK_FREQ  (1_600_000),
    .BAUD      (10_000),
    .OVERSAMPLE(16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .rx_en     (rx_en),
    .rx_done   (rx_done),
    .rx_out    (rx_out),
    .frame_err (frame_err),
    .parity_err(parity_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] kind, input logic [7:0] data, input bit chk_lat);
    ev_t e;
    e.kind      = kind;
    e.data      = data;
    e.chk_lat   = chk_lat;
    e.start_cyc = cyc;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drives one frame starting at a falling edge; the line is left at the stop-bit level.
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int bc, input logic par_good);
    rx = 1'b0;
    idle(bc);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      idle(bc);
    end
`ifdef UART_RX_PARITY_EN
    rx = (^d) ^ ~par_good;
    idle(bc);
`else
    if (!par_good) rx = 1'b1;
`endif
    rx = stop_b;
    idle(bc);
  endtask

  // Scoreboard monitor: every pulse must match the head of the queue; rx_out only moves on rx_done.
  always @(negedge clk) begin
    if (reset) begin
      exp_out = 8'h00;
    end else if (rx_done || frame_err || parity_err) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({rx_done, frame_err, parity_err}), 32'd0);
      end else begin
        ev_t e;
        e = sb.pop_front();
        check("pulse_kind", 32'({rx_done, frame_err, parity_err}), 32'(e.kind));
        if (e.kind == EV_DONE) begin
          check("rx_out_on_done", 32'(rx_out), 32'(e.data));
          exp_out = e.data;
          if (e.chk_lat)
            check($sformatf("done_latency_%0d_in_window", cyc - e.start_cyc),
                  32'((cyc - e.start_cyc >= LAT_LO) && (cyc - e.start_cyc <= LAT_HI)), 32'd1);
        end else begin
          check("rx_out_held_on_err", 32'(rx_out), 32'(exp_out));
        end
      end
    end else if (rx_out !== exp_out) begin
      check("rx_out_held", 32'(rx_out), 32'(exp_out));
    end
  end

  initial begin
    rx    = 1'b1;
    rx_en = 1'b1;
    reset = 1'b1;
    idle(3);
    check("reset_rx_out", 32'(rx_out), 32'h00);
    check("reset_rx_done", 32'(rx_done), 32'd0);
    check("reset_frame_err", 32'(frame_err), 32'd0);
    check("reset_parity_err", 32'(parity_err), 32'd0);
    reset = 1'b0;
    idle(20);

    push(EV_DONE, 8'hA5, 1'b1);
    send_frame(8'hA5, 1'b1, BIT, 1'b1);
    idle(400);
    check("rx_out_a5", 32'(rx_out), 32'hA5);

    // Low stop bit followed by a held-low line must give one frame_err only.
    push(EV_FERR, 8'h00, 1'b0);
    send_frame(8'h5A, 1'b0, BIT, 1'b1);
    idle(2000);
    check("rx_out_after_ferr", 32'(rx_out), 32'hA5);
    rx = 1'b1;
    idle(400);
    push(EV_DONE, 8'h00, 1'b1);
    send_frame(8'h00, 1'b1, BIT, 1'b1);
    idle(400);
    check("rx_out_00", 32'(rx_out), 32'h00);

    rx = 1'b0;
    idle(40);
    rx = 1'b1;
    idle(400);
    push(EV_DONE, 8'h3C, 1'b1);
    send_frame(8'h3C, 1'b1, BIT, 1'b1);
    idle(400);

    // Back-to-back frames at roughly +3% bit rate.
    push(EV_DONE, 8'h55, 1'b0);
    push(EV_DONE, 8'hFF, 1'b0);
    send_frame(8'h55, 1'b1, 155, 1'b1);
    send_frame(8'hFF, 1'b1, 155, 1'b1);
    idle(400);
    check("rx_out_ff", 32'(rx_out), 32'hFF);

    fork
      send_frame(8'hC3, 1'b1, BIT, 1'b1);
      begin
        idle(4 * BIT + BIT / 2);
        rx_en = 1'b0;
      end
    join
    idle(200);
    rx_en = 1'b1;
    idle(100);
    check("rx_out_after_abort", 32'(rx_out), 32'hFF);
    push(EV_DONE, 8'h81, 1'b1);
    send_frame(8'h81, 1'b1, BIT, 1'b1);
    idle(400);

    // Reset lands in data bit 5 of 0xE0 so the rest of the frame is a high line.
    fork
      send_frame(8'hE0, 1'b1, BIT, 1'b1);
      begin
        idle(6 * BIT + DIV * 4);
        reset = 1'b1;
        #1;
        check("midreset_rx_out", 32'(rx_out), 32'h00);
        check("midreset_rx_done", 32'(rx_done), 32'd0);
        check("midreset_frame_err", 32'(frame_err), 32'd0);
        check("midreset_parity_err", 32'(parity_err), 32'd0);
        idle(5);
        reset = 1'b0;
      end
    join
    idle(400);
    push(EV_DONE, 8'h7E, 1'b1);
    send_frame(8'h7E, 1'b1, BIT, 1'b1);
    idle(400);
    check("rx_out_7e", 32'(rx_out), 32'h7E);

`ifdef UART_RX_PARITY_EN
    push(EV_PERR, 8'h00, 1'b0);
    send_frame(8'h01, 1'b1, BIT, 1'b0);
    idle(400);
    check("rx_out_after_perr", 32'(rx_out), 32'h7E);
`endif

    for (int i = 0; i < 5000 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
